// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX ends of the link.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;
  localparam logic        PARITY_EVEN    = 1'b0;
  localparam logic        PARITY_ODD     = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter and data bit index for the UART transmitter.
module uart_tx_bit_timer #(
  parameter int unsigned PRESC_WIDTH = 6,
  parameter int unsigned IDX_W       = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   data_phase,
  input  logic [PRESC_WIDTH-1:0] prescale_q,
  output logic                   bit_done,
  output logic [IDX_W-1:0]       bit_idx
);

  logic [PRESC_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;

  // prescale_q is never 0 here; the top maps a 0 request to 1 when latching
  assign bit_done = en && (edge_cnt_q == (prescale_q - PRESC_WIDTH'(1)));
  assign bit_idx  = bit_idx_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_idx_d  = bit_idx_q;
    if (!en || bit_done) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESC_WIDTH'(1);
    end
    if (!data_phase) begin
      bit_idx_d = '0;
    end else if (bit_done) begin
      bit_idx_d = bit_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: 1 start, DATA_WIDTH data bits LSB first, optional parity, 1 stop.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = UART_DATA_BITS,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_WIDTH-1:0]  p_data,
  input  logic                   data_valid,
  input  logic                   parity_enable,
  input  logic                   parity_type,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic                   tx_out,
  output logic                   busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;

  logic                   bit_done;
  logic [IDX_W-1:0]       bit_idx;
  logic                   last_bit;

  uart_tx_bit_timer #(
    .PRESC_WIDTH (PRESC_WIDTH),
    .IDX_W       (IDX_W)
  ) u_bit_timer (
    .clk        (clk),
    .rstn       (rstn),
    .en         (state_q != IDLE),
    .data_phase (state_q == DATA),
    .prescale_q (presc_q),
    .bit_done   (bit_done),
    .bit_idx    (bit_idx)
  );

  assign last_bit = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign tx_out   = tx_q;
  assign busy     = busy_q;

  // Outputs are computed for the state being entered so the line changes on the same edge
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    presc_d   = presc_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (data_valid) begin
          state_d   = START;
          data_d    = p_data;
          par_en_d  = parity_enable;
          par_bit_d = (^p_data) ^ (parity_type == PARITY_ODD);
          presc_d   = (prescale == '0) ? PRESC_WIDTH'(1) : prescale;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        tx_d = data_q[bit_idx];
        if (bit_done) begin
          if (!last_bit) begin
            tx_d = data_q[bit_idx + IDX_W'(1)];
          end else if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
      end
      PARITY: begin
        tx_d = par_bit_q;
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      presc_q   <= presc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame against a frame-level line model.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_enable;
  logic       parity_type;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_frame dut (
    .clk           (clk),
    .rstn          (rstn),
    .p_data        (p_data),
    .data_valid    (data_valid),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .prescale      (prescale),
    .tx_out        (tx_out),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive don't-care inputs while a frame is in flight: 0 quiet, 1 random, 2 valid held high
  task automatic junk(input int mode);
    p_data        = 8'($urandom);
    parity_enable = 1'($urandom);
    parity_type   = 1'($urandom);
    prescale      = 6'($urandom);
    data_valid    = (mode == 2) ? 1'b1 : ((mode == 1) ? 1'($urandom) : 1'b0);
  endtask

  // Called just after a clock edge with the DUT idle; ends after checking the single idle cycle
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] ps, input int mode);
    int   p;
    logic lvl[$];
    p = (ps == 6'd0) ? 1 : int'(ps);
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) lvl.push_back(d[i]);
    if (pe) lvl.push_back(pt ? ~^d : ^d);
    lvl.push_back(1'b1);
    p_data        = d;
    parity_enable = pe;
    parity_type   = pt;
    prescale      = ps;
    data_valid    = 1'b1;
    for (int b = 0; b < lvl.size(); b++) begin
      for (int c = 0; c < p; c++) begin
        @(posedge clk); #1;
        check($sformatf("tx d=%02h p=%0d bit%0d cyc%0d", d, p, b, c), tx_out, lvl[b]);
        check($sformatf("busy d=%02h bit%0d cyc%0d", d, b, c), busy, 1'b1);
        junk(mode);
      end
    end
    @(posedge clk); #1;
    check($sformatf("gap_tx d=%02h", d), tx_out, 1'b1);
    check($sformatf("gap_busy d=%02h", d), busy, 1'b0);
    data_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_tx", tx_out, 1'b1);
      check("idle_busy", busy, 1'b0);
    end
  endtask

  initial begin
    rstn          = 1'b0;
    p_data        = '0;
    data_valid    = 1'b0;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    prescale      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    @(negedge clk) rstn = 1'b1;
    idle_cycles(2);

    // Directed frames
    run_frame(8'hA5, 1'b0, 1'b0, 6'd4, 0);
    idle_cycles(1);
    run_frame(8'h07, 1'b1, 1'b0, 6'd8, 0);
    run_frame(8'h07, 1'b1, 1'b1, 6'd8, 0);
    run_frame(8'h3C, 1'b0, 1'b0, 6'd0, 0);
    run_frame(8'h3C, 1'b1, 1'b1, 6'd1, 0);
    run_frame(8'h96, 1'b1, 1'b0, 6'd3, 1);
    idle_cycles(3);

    // Valid with 8'hFF held through the frame is ignored
    p_data = 8'h81; parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd2; data_valid = 1'b1;
    @(posedge clk); #1;
    p_data = 8'hFF; data_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      check($sformatf("ign_tx cyc%0d", i + 1), tx_out, (i + 1) < 2 ? 1'b0 : 1'b0 | ((8'h81 >> (((i + 1) / 2) - 1)) & 8'h01) != 0 || ((i + 1) >= 18));
      check("ign_busy", busy, 1'b1);
    end
    data_valid = 1'b0;
    idle_cycles(4);

    // Back-to-back with valid held high
    run_frame(8'h55, 1'b0, 1'b0, 6'd2, 2);
    run_frame(8'hAA, 1'b0, 1'b0, 6'd2, 2);
    idle_cycles(2);

    // Asynchronous reset in the middle of the data bits
    p_data = 8'hA5; parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd4; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_tx", tx_out, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tx", tx_out, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    run_frame(8'hA5, 1'b0, 1'b0, 6'd4, 0);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
                int'($urandom_range(0, 2)));
    end
    idle_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
